rr_arbiter_8: RTL
=================

Name: rr_arbiter_8

Overview:
- 8-requester round-robin arbiter that shares one decoded resource among eight masters, for example a shared bus, SPI port or LED/segment driver.
- Selects one requester, holds the grant while the requester keeps its request high, then rotates.
- Outputs both a 3-bit grant index and the matching one-hot grant vector, so downstream logic can use either form.
- A hold timeout stops any single requester from monopolising the resource.

Parameters:
- HOLD_MAX, default 16: maximum consecutive grant cycles before a forced release, applied only when other requests are pending. Legal range 2..255.
- CNT_W, default 8: width of the hold counter. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  8  request vector; bit k belongs to requester k.
- gnt  output  8  one-hot grant; bit k set means requester k owns the resource.
- gnt_idx  output  3  binary index of the current owner.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  single-cycle pulse marking a forced release.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: gnt=8'b00000000, gnt_idx=3'd0, gnt_valid=0, timeout=0, hold counter=0, state=IDLE, last-grant pointer=3'd7 (so requester 0 has first priority after reset).
- Reset mid-grant: the grant drops on the cycle after `rst` is sampled high. No GAP cycle is inserted.
- All outputs are registered.
- Invariants: gnt is always either all-zero or exactly one-hot, and gnt[gnt_idx]==gnt_valid.
- Pick function: scan indices ptr+1, ptr+2, … ptr+8 modulo 8 (wrap 7→0), and choose the first k with req[k]=1.
- State IDLE:
  - Outputs are idle (gnt=0, gnt_valid=0).
  - If req!=0 at edge t, go to GRANT: gnt=1<<k and gnt_idx=k become visible after edge t (one-cycle latency), ptr←k, counter←1.
- State GRANT, owner k:
  - req[k]=0 → go to GAP, gnt cleared.
  - req[k]=1 and counter>=HOLD_MAX and (req & ~(1<<k))!=0 → go to GAP, gnt cleared, timeout pulses for exactly one cycle together with the cleared gnt.
  - req[k]=1 and no other requester pending → stay in GRANT. The counter saturates at HOLD_MAX; the grant is kept indefinitely.
  - Otherwise → stay in GRANT, counter+1.
- State GAP:
  - Exactly one dead cycle with gnt=0; guarantees no overlap between owners.
  - Next edge: run the pick function from the updated ptr. If a requester is found, go to GRANT with that grant; if req==0, go to IDLE.
- Re-grant after GAP: the previous owner can be granted again only if no other requester is pending. This follows from ptr rotation.
- Handover cost: a release costs 2 cycles between the last cycle of owner A and the first cycle of owner B (GAP cycle plus grant registration).
- Simultaneous events:
  - Owner drops req on the same cycle the timeout would fire: treated as a normal release, timeout stays 0.
  - A new request arriving during GAP is considered in that GAP's pick.
- Request changes from non-owners during GRANT have no effect except on the timeout condition.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GAP=2'd2
  - N_REQ=8, IDX_W=3
- Sub-module rr_pick8: purely combinational. Inputs req[7:0] and ptr[2:0]; outputs found and idx[2:0]. Implemented as rotate, priority-encode, un-rotate.
- The controlling FSM, hold counter and output registers live in the top module.

Test Plan:
- Reset, then req=8'h01 from cycle 1 → gnt=8'h01 and gnt_idx=0 from cycle 2; gnt_valid=1; timeout never fires.
- req=8'hFF held constantly, with each owner dropping its bit after 3 grant cycles → grant order 0,1,2,…,7,0. Each handover shows exactly one gnt=0 cycle.
- HOLD_MAX=4, req[2] and req[5] held high continuously → requester 2 granted 4 cycles, then a GAP cycle with timeout=1, then requester 5 granted 4 cycles, then requester 2 again.
- HOLD_MAX=4, only req[3] high for 20 cycles → gnt=8'h08 for the whole 20 cycles, with no timeout and no GAP.
- Assert `rst` while requester 6 is granted and req=8'h40 stays high → gnt=0 the cycle after reset. After `rst` deasserts, requester 6 is re-granted once the pick runs from ptr=7.
- Wrap-around: ptr=7 (after requester 7 released), req=8'h81 → requester 0 is granted, not 7.
- Run all scenarios with assertions for one-hot gnt and gnt[gnt_idx]==gnt_valid.

Source files
------------

// File: rtl/rr_arbiter_8_pkg.sv
// Shared types and constants for the 8-requester round-robin arbiter.
// The pick unit and the controlling FSM both import this package.
package rr_arbiter_8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_pick8.sv
// Combinational round-robin pick: first requester after ptr, wrapping 7 -> 0.
// Rotates req so position 0 is ptr+1, priority-encodes, then un-rotates.
module rr_pick8
  import rr_arbiter_8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   shamt;
  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  // Shift amount is 1..8, so the doubled vector always yields a full rotation.
  assign shamt = {1'b0, ptr} + (IDX_W+1)'(1);
  assign rot   = N_REQ'({req, req} >> shamt);

  always_comb begin
    found = 1'b0;
    off   = '0;
    // Descending scan: the last hit written is the lowest offset.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = IDX_W'(i);
      end
    end
  end

  assign idx = ptr + off + IDX_W'(1);

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with hold-while-requested grants,
// a one-cycle dead gap between owners, and a hold timeout.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_d;
  logic [IDX_W-1:0] gnt_idx_d;
  logic             gnt_valid_d;
  logic             timeout_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;
  logic             others_pending;
  logic             hold_done;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // In GRANT, gnt is the owner's one-hot, so masking with it isolates the rest.
  assign owner_req      = req[gnt_idx];
  assign others_pending = |(req & ~gnt);
  assign hold_done      = (cnt_q >= CNT_W'(HOLD_MAX));

  always_comb begin
    // NOTE: every next-state value gets a default first so no branch infers a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt;
    gnt_idx_d   = gnt_idx;
    gnt_valid_d = gnt_valid;
    timeout_d   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pick_found) begin
          state_d     = ST_GRANT;
          ptr_d       = pick_idx;
          cnt_d       = CNT_W'(1);
          gnt_d       = idx_to_onehot(pick_idx);
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GRANT: begin
        if (!owner_req || (hold_done && others_pending)) begin
          state_d     = ST_GAP;
          cnt_d       = '0;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          // An owner that releases on its own never counts as a forced release.
          timeout_d   = owner_req;
        end else if (!hold_done) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IDX_W'(N_REQ - 1);
      cnt_q     <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      gnt_idx   <= gnt_idx_d;
      gnt_valid <= gnt_valid_d;
      timeout   <= timeout_d;
    end
  end

endmodule
